// File: rtl/demux_4to1_router_n_if.sv
// Purpose : bundled signals for the 1:4 registered stream router.
// Ports   : producer side  - ch_in, sel, in_valid (to router), in_ready (from router)
//           consumer side  - ch_1..ch_4, out_valid (from router), out_ready (to router)
//           optional       - cnt_1..cnt_4 delivered-word counters (DEMUX_ROUTER_CNT_EN)
// Modports: slave  = the router itself
//           master = the environment driving the router
// Config  : `define DEMUX_ROUTER_CNT_EN adds the cnt_1..cnt_4 counter signals.
interface demux_4to1_router_n_if #(
  parameter int unsigned DATA_WIDTH = 64
);
  localparam int unsigned CNT_W = 16;

  logic [DATA_WIDTH-1:0] ch_in;
  logic [1:0]            sel;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] ch_1;
  logic [DATA_WIDTH-1:0] ch_2;
  logic [DATA_WIDTH-1:0] ch_3;
  logic [DATA_WIDTH-1:0] ch_4;
  logic [3:0]            out_valid;
  logic [3:0]            out_ready;
`ifdef DEMUX_ROUTER_CNT_EN
  logic [CNT_W-1:0]      cnt_1;
  logic [CNT_W-1:0]      cnt_2;
  logic [CNT_W-1:0]      cnt_3;
  logic [CNT_W-1:0]      cnt_4;

  modport slave (
    input  ch_in, sel, in_valid, out_ready,
    output in_ready, ch_1, ch_2, ch_3, ch_4, out_valid,
    output cnt_1, cnt_2, cnt_3, cnt_4
  );

  modport master (
    output ch_in, sel, in_valid, out_ready,
    input  in_ready, ch_1, ch_2, ch_3, ch_4, out_valid,
    input  cnt_1, cnt_2, cnt_3, cnt_4
  );
`else
  modport slave (
    input  ch_in, sel, in_valid, out_ready,
    output in_ready, ch_1, ch_2, ch_3, ch_4, out_valid
  );

  modport master (
    output ch_in, sel, in_valid, out_ready,
    input  in_ready, ch_1, ch_2, ch_3, ch_4, out_valid
  );
`endif
endinterface

// File: rtl/demux_4to1_router_n.sv
// Purpose : registered 1:4 stream router with valid/ready flow control. Each
//           input word carries a 2-bit destination and is parked in a
//           single-entry output register for that channel until its consumer
//           takes it. A stalled target blocks the input (head-of-line); other
//           full channels keep draining independently.
// Ports   : clk  - clock, all state on the rising edge
//           rst  - asynchronous reset, active-high
//           bus  - demux_4to1_router_n_if.slave
//                  ch_in/sel/in_valid in, in_ready out (combinational),
//                  ch_1..ch_4/out_valid out (registered), out_ready in,
//                  cnt_1..cnt_4 out (registered, DEMUX_ROUTER_CNT_EN only)
// Config  : `define DEMUX_ROUTER_CNT_EN adds 16-bit wrapping per-channel
//           delivered-word counters; routing is identical in both builds.
module demux_4to1_router_n #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  demux_4to1_router_n_if.slave  bus
);

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

  ch_state_e             state_q [NUM_CH];
  ch_state_e             state_d [NUM_CH];
  logic [DATA_WIDTH-1:0] data_q  [NUM_CH];
  logic [DATA_WIDTH-1:0] data_d  [NUM_CH];

  logic [NUM_CH-1:0]     valid_c;
  logic [NUM_CH-1:0]     handshake_c;
  logic [NUM_CH-1:0]     load_c;
  logic                  in_ready_c;
  logic                  accept_c;

  // Channel occupancy is the FSM state itself.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      valid_c[k] = (state_q[k] == FULL);
    end
  end

  // A word can enter when its target is empty or is being drained this cycle.
  // No dependence on in_valid, so a producer may wait on in_ready safely.
  assign in_ready_c  = !valid_c[bus.sel] | bus.out_ready[bus.sel];
  assign accept_c    = bus.in_valid & in_ready_c;
  assign handshake_c = valid_c & bus.out_ready;
  assign load_c      = accept_c ? NUM_CH'(4'b0001 << bus.sel) : '0;

  // Per-channel next state and data; only the selected channel loads.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      state_d[k] = state_q[k];
      data_d[k]  = data_q[k];
      case (state_q[k])
        EMPTY: begin
          if (load_c[k]) state_d[k] = FULL;
        end
        FULL: begin
          // Drain with a simultaneous refill stays FULL with new data.
          if (handshake_c[k] && !load_c[k]) state_d[k] = EMPTY;
        end
        default: state_d[k] = EMPTY;
      endcase
      if (load_c[k]) data_d[k] = bus.ch_in;
    end
  end

  // State and data registers; buffered words are discarded on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k] <= EMPTY;
        data_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k] <= state_d[k];
        data_q[k]  <= data_d[k];
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = valid_c;
  assign bus.ch_1      = data_q[0];
  assign bus.ch_2      = data_q[1];
  assign bus.ch_3      = data_q[2];
  assign bus.ch_4      = data_q[3];

`ifdef DEMUX_ROUTER_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];

  // Delivered-word counters, wrapping naturally at 16 bits.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_d[k] = cnt_q[k] + CNT_W'(handshake_c[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign bus.cnt_1 = cnt_q[0];
  assign bus.cnt_2 = cnt_q[1];
  assign bus.cnt_3 = cnt_q[2];
  assign bus.cnt_4 = cnt_q[3];
`endif

  // SEL_W documents the destination field width carried on the bus.
  if (SEL_W != $bits(bus.sel)) begin : g_sel_width_check
    $error("sel width mismatch");
  end

endmodule
